fetch_unit: RTL and testbench

Instruction fetch stage feeding the decoder. Holds the program counter, issues one word-aligned read at a time to the instruction memory through a valid/ready request channel, and hands each returned 32-bit instruction word plus its PC to the decoder through a one-entry valid/ready output buffer. Accepts a redirect (branch/jump target) from later stages and squashes any in-flight or buffered instruction fetched from the old path.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the PC, issues one word read at a time to instruction memory over a
// valid/ready request channel, and presents each returned word with its PC
// to the decoder through a one-entry valid/ready buffer. A redirect replaces
// the PC and squashes any in-flight or buffered instruction from the old path.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr      read request channel (addr is always pc)
//   imem_resp_valid/data           read response, one per accepted request
//   redirect_valid/redirect_pc     new fetch target from later stages
//   out_valid/ready                decoder handshake
//   out_instruction/out_pc         fetched word and its address
//   out_fault                      misaligned pc; out_instruction is NOP_INSTR
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc,
   output logic        out_fault
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_OUT,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic        squash;   // a redirect arrived while a response is still owed

   logic        pc_misaligned;

   assign pc_misaligned  = (pc[1:0] != 2'b00);
   assign imem_req_valid = (state == S_REQ) && !rst && !redirect_valid && !pc_misaligned;
   assign imem_req_addr  = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_REQ;
         pc              <= RESET_PC;
         req_pc          <= '0;
         squash          <= 1'b0;
         out_valid       <= 1'b0;
         out_instruction <= NOP_INSTR;
         out_pc          <= '0;
         out_fault       <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
               end else if (pc_misaligned) begin
                  out_valid       <= 1'b1;
                  out_fault       <= 1'b1;
                  out_pc          <= pc;
                  out_instruction <= NOP_INSTR;
                  state           <= S_OUT;
               end else if (imem_req_ready) begin
                  req_pc <= pc;
                  state  <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (imem_resp_valid) begin
                  if (squash || redirect_valid) begin
                     // Stale response: consume it and discard.
                     squash <= 1'b0;
                     state  <= S_REQ;
                     if (redirect_valid) begin
                        pc <= redirect_pc;
                     end
                  end else begin
                     out_instruction <= imem_resp_data;
                     out_pc          <= req_pc;
                     out_fault       <= 1'b0;
                     out_valid       <= 1'b1;
                     pc              <= req_pc + 32'd4;
                     state           <= S_OUT;
                  end
               end else if (redirect_valid) begin
                  // Must still wait for the owed response before re-requesting.
                  pc     <= redirect_pc;
                  squash <= 1'b1;
               end
            end

            S_OUT: begin
               if (redirect_valid) begin
                  pc        <= redirect_pc;
                  out_valid <= 1'b0;
                  state     <= S_REQ;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= out_fault ? S_HALT : S_REQ;
               end
            end

            S_HALT: begin
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= S_REQ;
               end
            end

            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A default instance (RESET_PC=0) runs the
// main scenarios; a second instance with RESET_PC=FFFF_FFFC covers pc wrap
// and reset during an outstanding request. Both share the input stimulus and
// each is held in reset while the other is exercised.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst2;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic        imem_req_valid,  w_req_valid;
   logic [31:0] imem_req_addr,   w_req_addr;
   logic        out_valid,       w_out_valid;
   logic [31:0] out_instruction, w_out_instruction;
   logic [31:0] out_pc,          w_out_pc;
   logic        out_fault,       w_out_fault;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .out_fault       (out_fault)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_wrap (
      .clk             (clk),
      .rst             (rst2),
      .imem_req_valid  (w_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (w_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (w_out_valid),
      .out_ready       (out_ready),
      .out_instruction (w_out_instruction),
      .out_pc          (w_out_pc),
      .out_fault       (w_out_fault)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs are driven 1 time unit after the rising edge; outputs are
   // sampled 1 time unit later, well before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      rst2            = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      out_ready       = 1'b1;

      tick();
      tick();
      settle();
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instruction, 32'h0000_0013);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_fault", {31'd0, out_fault}, 32'd0);

      // Basic fetch, zero-wait memory.
      rst = 1'b0;
      imem_req_ready = 1'b1;
      settle();
      check("f1_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("f1_req_addr", imem_req_addr, 32'h0);
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0050_0093;
      settle();
      check("f1_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("f1_wait_no_out", {31'd0, out_valid}, 32'd0);
      tick();
      imem_resp_valid = 1'b0;
      settle();
      check("f1_out_valid", {31'd0, out_valid}, 32'd1);
      check("f1_out_instr", out_instruction, 32'h0050_0093);
      check("f1_out_pc", out_pc, 32'h0);
      check("f1_out_fault", {31'd0, out_fault}, 32'd0);
      tick();
      settle();
      check("f1_next_valid", {31'd0, imem_req_valid}, 32'd1);
      check("f1_next_addr", imem_req_addr, 32'h4);
      check("f1_out_clr", {31'd0, out_valid}, 32'd0);

      // Backpressure in S_OUT.
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h00A0_0113;
      tick();
      imem_resp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_instr", out_instruction, 32'h00A0_0113);
         check("bp_out_pc", out_pc, 32'h4);
         check("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      settle();
      check("bp_still_valid", {31'd0, out_valid}, 32'd1);
      tick();
      settle();
      check("bp_next_valid", {31'd0, imem_req_valid}, 32'd1);
      check("bp_next_addr", imem_req_addr, 32'h8);

      // Redirect while waiting; response arrives 3 cycles after accept.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      settle();
      check("rw_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      settle();
      check("rw_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      settle();
      check("rw_no_out", {31'd0, out_valid}, 32'd0);
      tick();
      imem_resp_valid = 1'b0;
      settle();
      check("rw_dropped", {31'd0, out_valid}, 32'd0);
      check("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rw_req_addr", imem_req_addr, 32'h100);
      tick();
      settle();
      check("rw_dropped2", {31'd0, out_valid}, 32'd0);

      // Redirect in the same cycle as the response.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1111_1111;
      redirect_valid  = 1'b1;
      redirect_pc     = 32'h300;
      tick();
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      settle();
      check("rs_dropped", {31'd0, out_valid}, 32'd0);
      check("rs_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rs_req_addr", imem_req_addr, 32'h300);

      // Misaligned redirect -> fault, halt, then recover by redirect.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      settle();
      check("mf_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      settle();
      check("mf_misaligned_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      settle();
      check("mf_out_valid", {31'd0, out_valid}, 32'd1);
      check("mf_out_fault", {31'd0, out_fault}, 32'd1);
      check("mf_out_instr", out_instruction, 32'h0000_0013);
      check("mf_out_pc", out_pc, 32'h102);
      check("mf_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      settle();
      check("mf_halt_out", {31'd0, out_valid}, 32'd0);
      check("mf_halt_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      tick();
      settle();
      check("mf_halt_req2", {31'd0, imem_req_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      settle();
      check("mf_rec_valid", {31'd0, imem_req_valid}, 32'd1);
      check("mf_rec_addr", imem_req_addr, 32'h200);
      tick();
      settle();
      check("mf_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      check("mf_hold_addr", imem_req_addr, 32'h200);

      // Wrap instance: RESET_PC = FFFF_FFFC.
      rst  = 1'b1;
      rst2 = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      settle();
      check("main_rst_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("w_req_valid", {31'd0, w_req_valid}, 32'd1);
      check("w_req_addr", w_req_addr, 32'hFFFF_FFFC);
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0073;
      tick();
      imem_resp_valid = 1'b0;
      settle();
      check("w_out_valid", {31'd0, w_out_valid}, 32'd1);
      check("w_out_pc", w_out_pc, 32'hFFFF_FFFC);
      check("w_out_instr", w_out_instruction, 32'h0000_0073);
      tick();
      settle();
      check("w_wrap_valid", {31'd0, w_req_valid}, 32'd1);
      check("w_wrap_addr", w_req_addr, 32'h0);

      // Reset while waiting for a response.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst2 = 1'b1;
      tick();
      settle();
      check("wr_out_valid", {31'd0, w_out_valid}, 32'd0);
      check("wr_req_in_rst", {31'd0, w_req_valid}, 32'd0);
      rst2 = 1'b0;
      settle();
      check("wr_req_valid", {31'd0, w_req_valid}, 32'd1);
      check("wr_req_addr", w_req_addr, 32'hFFFF_FFFC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
